// File: rtl/neuron_pkg.sv
// Shared types and width helpers for the neuron multiply-accumulate stage.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

    function automatic int acc_w(input int bits);
        return bits + 25;
    endfunction

    // Saturation bounds for a signed value of the given width.
    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/sat_accumulator.sv
// Signed saturating accumulator: adds one addend per enabled cycle and
// clamps to the representable range, flagging each clamp with a pulse.
module sat_accumulator
    import neuron_pkg::*;
#(
    parameter int W = 33
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                en,
    input  logic signed [W-1:0] addend,
    output logic signed [W-1:0] sum,
    output logic                sat
);

    localparam logic signed [63:0]  MAX_L = sat_max(W);
    localparam logic signed [63:0]  MIN_L = sat_min(W);
    localparam logic signed [W-1:0] MAX_V = MAX_L[W-1:0];
    localparam logic signed [W-1:0] MIN_V = MIN_L[W-1:0];

    logic signed [W:0]   sum_ext;
    logic signed [W-1:0] sum_next;
    logic                ovf;

    // One guard bit is enough: the top two bits disagree exactly when the
    // exact sum lies outside the W-bit range, and the guard bit gives its sign.
    always_comb begin
        sum_ext  = {sum[W-1], sum} + {addend[W-1], addend};
        ovf      = sum_ext[W] ^ sum_ext[W-1];
        sum_next = sum_ext[W-1:0];
        if (ovf) begin
            sum_next = sum_ext[W] ? MIN_V : MAX_V;
        end
        sat = en & ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum_next;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Streaming signed dot-product stage: product register then saturating
// accumulate, one neuron of COUNTER_END terms at a time.
//   state | meaning
//   IDLE  | waiting for start, in_ready low
//   ACCUM | accepting beats until COUNTER_END have been taken
//   DRAIN | last product still in the product register
//   DONE  | result held with sum_valid until sum_ack
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int W_BITS      = 15,
    parameter int COUNTER_END = 784
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [BITS:0]           x_in,
    input  logic signed [W_BITS:0]         w_in,
    output logic signed [acc_w(BITS)-1:0]  mult_sum_out,
    output logic [31:0]                    counter,
    output logic                           sum_valid,
    input  logic                           sum_ack,
    output logic                           busy,
    output logic                           overflow
);

    localparam int ACC_W  = acc_w(BITS);
    localparam int PROD_W = BITS + W_BITS + 2;

    mac_state_t                state;
    mac_state_t                state_next;
    logic [31:0]               accept_cnt;
    logic [31:0]               accept_cnt_next;
    logic                      accept;
    logic                      last_accept;
    logic                      start_accept;
    logic                      acc_clear;
    logic signed [PROD_W-1:0]  prod_q;
    logic                      prod_valid;
    logic signed [ACC_W-1:0]   addend;
    logic                      sat;

    assign accept      = in_valid & in_ready;
    assign last_accept = accept && (accept_cnt == 32'(COUNTER_END - 1));
    assign addend      = ACC_W'(prod_q);
    assign busy        = (state != IDLE);
    assign sum_valid   = (state == DONE);

    always_comb begin
        state_next   = state;
        start_accept = 1'b0;
        acc_clear    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = ACCUM;
                    start_accept = 1'b1;
                end
            end
            ACCUM: begin
                if (last_accept) begin
                    state_next = DRAIN;
                end
            end
            // The final product is always in flight here, so it lands this edge.
            DRAIN: state_next = DONE;
            DONE: begin
                if (sum_ack) begin
                    acc_clear = 1'b1;
                    if (start) begin
                        state_next   = ACCUM;
                        start_accept = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        acc_clear = acc_clear | start_accept;

        accept_cnt_next = accept_cnt;
        if (start_accept) begin
            accept_cnt_next = '0;
        end else if (accept) begin
            accept_cnt_next = accept_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            accept_cnt <= '0;
            in_ready   <= 1'b0;
            prod_q     <= '0;
            prod_valid <= 1'b0;
            counter    <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            accept_cnt <= accept_cnt_next;
            in_ready   <= (state_next == ACCUM) && (accept_cnt_next < 32'(COUNTER_END));
            prod_valid <= accept;
            if (accept) begin
                prod_q <= PROD_W'(x_in) * PROD_W'(w_in);
            end
            if (acc_clear) begin
                counter <= '0;
            end else if (prod_valid) begin
                counter <= counter + 32'd1;
            end
            if (start_accept) begin
                overflow <= 1'b0;
            end else if (sat) begin
                overflow <= 1'b1;
            end
        end
    end

    sat_accumulator #(
        .W (ACC_W)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (acc_clear),
        .en     (prod_valid),
        .addend (addend),
        .sum    (mult_sum_out),
        .sat    (sat)
    );

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: a 4-term instance for the functional
// cases and a 600-term instance for the saturation case.
module tb_neuron_mac;

    typedef struct {
        logic signed [32:0] sum;
        logic [31:0]        cnt;
        logic               ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic               start, in_valid, sum_ack;
    logic signed [8:0]  x_in;
    logic signed [15:0] w_in;
    logic               in_ready, sum_valid, busy, overflow;
    logic signed [32:0] mult_sum_out;
    logic [31:0]        counter;

    logic               s_start, s_in_valid, s_sum_ack;
    logic signed [8:0]  s_x_in;
    logic signed [15:0] s_w_in;
    logic               s_in_ready, s_sum_valid, s_busy, s_overflow;
    logic signed [32:0] s_mult_sum_out;
    logic [31:0]        s_counter;

    exp_t q[$];
    exp_t sq[$];
    int checks = 0;
    int errors = 0;

    logic signed [8:0]  xa[4];
    logic signed [15:0] wa[4];

    always #5 clk = ~clk;

    neuron_mac #(.BITS(8), .W_BITS(15), .COUNTER_END(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
        .mult_sum_out(mult_sum_out), .counter(counter), .sum_valid(sum_valid),
        .sum_ack(sum_ack), .busy(busy), .overflow(overflow)
    );

    neuron_mac #(.BITS(8), .W_BITS(15), .COUNTER_END(600)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .x_in(s_x_in), .w_in(s_w_in),
        .mult_sum_out(s_mult_sum_out), .counter(s_counter), .sum_valid(s_sum_valid),
        .sum_ack(s_sum_ack), .busy(s_busy), .overflow(s_overflow)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: compare each new result against the oldest expectation.
    logic sv_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (sum_valid && !sv_prev) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %0d with no expected entry", mult_sum_out);
            end else begin
                e = q.pop_front();
                chk("result_sum", mult_sum_out, e.sum);
                chk("result_counter", counter, e.cnt);
                chk("result_overflow", overflow, e.ovf);
            end
        end
        sv_prev = sum_valid;
    end

    logic ssv_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (s_sum_valid && !ssv_prev) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sat_result: got sum %0d with no expected entry", s_mult_sum_out);
            end else begin
                e = sq.pop_front();
                chk("sat_result_sum", s_mult_sum_out, e.sum);
                chk("sat_result_counter", s_counter, e.cnt);
                chk("sat_result_overflow", s_overflow, e.ovf);
            end
        end
        ssv_prev = s_sum_valid;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic ack_and_check_idle();
        sum_ack = 1'b1;
        @(posedge clk); #1;
        sum_ack = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_sum", mult_sum_out, 0);
        chk("idle_counter", counter, 0);
        chk("idle_in_ready", in_ready, 0);
    endtask

    // gap > 0 holds in_valid low for gap-1 cycles between beats.
    task automatic send_set(input int gap);
        int n;
        for (int i = 0; i < 4; i++) begin
            x_in = xa[i];
            w_in = wa[i];
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: beat %0d never accepted", i);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (gap > 0 && i < 3) begin
                @(negedge clk);
                chk("counter_before_term", counter, i);
                @(negedge clk);
                chk("counter_after_term", counter, i + 1);
                repeat (gap - 2) @(negedge clk);
            end
        end
        @(negedge clk);
        chk("in_ready_after_last", in_ready, 0);
        chk("sum_valid_early", sum_valid, 0);
        chk("counter_drain", counter, 3);
        @(negedge clk);
        chk("sum_valid_on_time", sum_valid, 1);
    endtask

    task automatic load_base_set();
        xa[0] = 9'sd1;  xa[1] = 9'sd2;   xa[2] = 9'sd3;  xa[3] = 9'sd4;
        wa[0] = 16'sd5; wa[1] = -16'sd6; wa[2] = 16'sd7; wa[3] = 16'sd8;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 0; in_valid = 0; sum_ack = 0; x_in = '0; w_in = '0;
        s_start = 0; s_in_valid = 0; s_sum_ack = 0; s_x_in = '0; s_w_in = '0;

        repeat (3) begin
            x_in = 9'($urandom); w_in = 16'($urandom);
            start = 1'($urandom); in_valid = 1'($urandom); sum_ack = 1'($urandom);
            @(posedge clk); #1;
        end
        start = 0; in_valid = 0; sum_ack = 0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sum", mult_sum_out, 0);
        chk("rst_counter", counter, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back beats: 5 - 12 + 21 + 32 = 46.
        load_base_set();
        pulse_start();
        q.push_back('{sum: 33'sd46, cnt: 32'd4, ovf: 1'b0});
        send_set(0);
        ack_and_check_idle();

        // in_valid pattern 1,0,0,1,...
        pulse_start();
        q.push_back('{sum: 33'sd46, cnt: 32'd4, ovf: 1'b0});
        send_set(3);
        ack_and_check_idle();

        // Reset mid-ACCUM with the second product still in flight.
        pulse_start();
        in_valid = 1'b1; x_in = 9'sd1; w_in = 16'sd5;
        @(posedge clk); #1;
        x_in = 9'sd2; w_in = -16'sd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_counter", counter, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", mult_sum_out, 0);
        chk("mid_rst_counter", counter, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_sum", mult_sum_out, 0);
        chk("post_rst_counter", counter, 0);
        pulse_start();
        q.push_back('{sum: 33'sd46, cnt: 32'd4, ovf: 1'b0});
        send_set(0);

        // start and sum_ack together in DONE: straight into the next neuron.
        start = 1'b1; sum_ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; sum_ack = 1'b0;
        @(negedge clk);
        chk("b2b_busy", busy, 1);
        chk("b2b_sum_valid", sum_valid, 0);
        chk("b2b_counter", counter, 0);
        chk("b2b_sum", mult_sum_out, 0);
        chk("b2b_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            xa[i] = 9'sd1;
            wa[i] = -16'sd1;
        end
        q.push_back('{sum: -33'sd4, cnt: 32'd4, ovf: 1'b0});
        send_set(0);
        ack_and_check_idle();

        // 2^23 per term; the 512th term would reach 2^32 and clamps to 2^32-1.
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        sq.push_back('{sum: 33'sd4294967295, cnt: 32'd600, ovf: 1'b1});
        s_x_in = 9'h100;
        s_w_in = 16'h8000;
        s_in_valid = 1'b1;
        n = 0;
        while (!s_sum_valid && n < 800) begin
            @(negedge clk);
            n++;
            if (s_counter == 32'd511) begin
                chk("sat_ovf_before", s_overflow, 0);
                chk("sat_sum_before", s_mult_sum_out, 64'sd4286578688);
            end
            if (s_counter == 32'd512) begin
                chk("sat_ovf_at_512", s_overflow, 1);
                chk("sat_sum_at_512", s_mult_sum_out, 64'sd4294967295);
            end
        end
        s_in_valid = 1'b0;
        chk("sat_done_reached", s_sum_valid, 1);
        chk("sat_in_ready_done", s_in_ready, 0);
        s_sum_ack = 1'b1;
        @(posedge clk); #1;
        s_sum_ack = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size() + sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Streaming multiply-accumulate stage that sits directly upstream of the neuron activation stage. For one neuron it accepts COUNTER_END (input, weight) pairs over a valid/ready handshake, forms their signed dot product in a saturating accumulator, and presents the result on `mult_sum_out` together with the running term `counter`. The activation stage adds the bias when `counter >= COUNTER_END` and applies the optional ReLU.

## Interface
Parameters:
- `BITS`, 8: input activation is signed `BITS+1` bits; accumulator/result is signed `BITS+25` bits (ACC_W).
- `W_BITS`, 15: weight is signed `W_BITS+1` bits; legal range 1..23 so product width ≤ ACC_W.
- `COUNTER_END`, 784: terms per neuron; ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  pulse: begin a new neuron.
- `in_valid`  in  1  `x_in`/`w_in` valid.
- `in_ready`  out  1  stage accepts a beat.
- `x_in`  in  BITS+1  signed activation.
- `w_in`  in  W_BITS+1  signed weight.
- `mult_sum_out`  out  ACC_W  signed accumulated sum.
- `counter`  out  32  terms accumulated so far.
- `sum_valid`  out  1  result final and held.
- `sum_ack`  in  1  consumer has taken result.
- `busy`  out  1  state ≠ IDLE.
- `overflow`  out  1  sticky saturation flag for current neuron.

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE: `in_ready`=0. `start` → ACCUM; clears accumulator, `counter`, accept count, `overflow`.
- ACCUM: `in_ready`=1 while accept count < COUNTER_END. A beat is accepted on `in_valid & in_ready`. Accepting beat COUNTER_END → DRAIN.
- DRAIN: `in_ready`=0; waits for the last product to be accumulated, then → DONE.
- DONE: `sum_valid`=1; `mult_sum_out` and `counter` (= COUNTER_END) held. Transitions:
  - `sum_ack` → IDLE, with `counter` and the accumulator cleared.
  - `sum_ack & start` in the same cycle → ACCUM directly, cleared (back-to-back neurons).
- `start` is ignored in ACCUM and DRAIN, and in DONE without `sum_ack`.
- Arithmetic:
  - Product is full precision and sign-extended to ACC_W+1.
  - The sum is computed in ACC_W+1 bits and clamped to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - Any clamp sets `overflow`, which stays high until the next `start` or reset.
- `counter` increments once per accumulated term, not per accepted beat.

## Timing
- Reset (`rst_n`=0 at a clock edge), from any state including mid-ACCUM:
  - Next cycle: IDLE with `in_ready`=0, `mult_sum_out`=0, `counter`=0, `sum_valid`=0, `busy`=0, `overflow`=0.
  - The in-flight product is discarded.
- Two-stage pipeline, stage 1 = product register, stage 2 = accumulate:
  - Beat accepted at edge t → accumulated and `counter` incremented at edge t+1.
  - Final beat at edge t → DONE entered at edge t+1; `sum_valid` is high in the cycle after that edge.
- `in_ready` is registered from state and accept count. It is never high in the cycle after the COUNTER_END-th accept.
- Gaps in `in_valid` insert bubbles. The result is unaffected; `counter` only advances on real terms.
- COUNTER_END=1: a single accept goes ACCUM→DRAIN→DONE.

## Structure
- Package `neuron_pkg` holds:
  - state enum `mac_state_t` (IDLE, ACCUM, DRAIN, DONE);
  - function `acc_w(BITS)` = BITS+25;
  - saturation min/max constants as functions of width.
- One sub-module, `sat_accumulator`:
  - inputs: ACC_W-wide signed addend, enable, clear;
  - outputs: registered sum and saturation pulse.
- The FSM, handshake and product register stay in `neuron_mac`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random inputs → all outputs 0, state IDLE, `in_ready`=0.
- COUNTER_END=4, x={1,2,3,4}, w={5,−6,7,8}, back-to-back → `mult_sum_out`=46, `counter`=4, `sum_valid` 2 cycles after 4th accept, `overflow`=0.
- Same data with `in_valid` toggling 1,0,0,1,… → same 46/4; `counter` steps only on accepted terms; `in_ready` low after 4th accept.
- BITS=8, W_BITS=15, COUNTER_END=600, x=−256, w=−32768 every beat → saturates at 2^32−1 after 512 terms, `overflow`=1, `counter`=600.
- `rst_n` low during ACCUM after 2 terms, then `start` with the 4-term set → clean result 46, no residue.
- In DONE, assert `start` and `sum_ack` together, then feed x={1,1,1,1}, w={−1,−1,−1,−1} → immediate ACCUM; second result −4, `counter`=4.
